// File: rtl/axi_ocp_pkg.sv
// rtl/axi_ocp_pkg.sv - shared AXI/OCP default widths and address-packet layout
package axi_ocp_pkg;

    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_ADDR_W = 32;

    // Field order {id, len, addr}; modules with other widths redeclare the same layout.
    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_ADDR_W-1:0] addr;
    } addr_pkt_t;

endpackage

// File: rtl/axi_rd_addr_splitter_fifo.sv
// rtl/axi_rd_addr_splitter_fifo.sv - parametrised FIFO; a pushed entry becomes poppable one edge later
module axi_rd_addr_splitter_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_vis;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Full tracks the real write pointer; empty tracks a one-edge-delayed copy.
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty = (rd_ptr == wr_ptr_vis);
    assign rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_ptr_vis <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            wr_ptr_vis <= wr_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axi_rd_addr_splitter.sv
// rtl/axi_rd_addr_splitter.sv - AR FIFO plus IDLE/ACTIVE output stage emitting address packets
// AXI_RD_BURST_SPLIT_EN: split each AR into packets of at most MAX_BURST beats.
module axi_rd_addr_splitter
    import axi_ocp_pkg::*;
#(
    parameter int ID_W       = AXI_ID_W,
    parameter int LEN_W      = AXI_LEN_W,
    parameter int ADDR_W     = AXI_ADDR_W,
    parameter int DEPTH      = 4,
    parameter int MAX_BURST  = 16,
    parameter int BEAT_BYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              arvalid,
    output logic              arready,
    input  logic [ID_W-1:0]   arid,
    input  logic [LEN_W-1:0]  arlen,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              hold_in,
    output logic              pkt_vld,
    output logic [ID_W-1:0]   pkt_id,
    output logic [LEN_W-1:0]  pkt_len,
    output logic [ADDR_W-1:0] pkt_addr,
    output logic              pkt_last
);
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } packet_t;

    typedef enum logic {IDLE, ACTIVE} state_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_BURST < 1 || MAX_BURST > (1 << LEN_W) ||
        (MAX_BURST & (MAX_BURST - 1)) != 0 || BEAT_BYTES < 1 || (BEAT_BYTES & (BEAT_BYTES - 1)) != 0) begin : g_bad_cfg
        $error("axi_rd_addr_splitter: illegal DEPTH/MAX_BURST/BEAT_BYTES");
    end

    state_t            state_q;
    state_t            state_d;
    packet_t           wr_pkt;
    packet_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              load;
    logic              consume;
    logic [ID_W-1:0]   id_d;
    logic [LEN_W-1:0]  len_d;
    logic [ADDR_W-1:0] addr_d;
    logic              last_d;

`ifdef AXI_RD_BURST_SPLIT_EN
    localparam logic [LEN_W:0] ONE        = (LEN_W+1)'(1);
    localparam logic [LEN_W:0] MAXB       = (LEN_W+1)'(MAX_BURST);
    localparam int             BEAT_SHIFT = $clog2(BEAT_BYTES);

    // Beats still owed by the current AR after the packet now in the output register.
    logic [LEN_W:0] rem_q;
    logic [LEN_W:0] rem_d;
    logic [LEN_W:0] avail;
    logic [LEN_W:0] beats;
    logic           advance;
`endif

    assign wr_pkt  = {arid, arlen, araddr};
    assign arready = rst && !fifo_full;
    assign pkt_vld = (state_q == ACTIVE);
    assign consume = pkt_vld && !hold_in;

    axi_rd_addr_splitter_fifo #(
        .WIDTH ($bits(packet_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (arvalid && arready),
        .wdata (wr_pkt),
        .full  (fifo_full),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
`ifdef AXI_RD_BURST_SPLIT_EN
        advance = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    load    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (consume) begin
                    if (pkt_last && !fifo_empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else if (pkt_last) begin
                        state_d = IDLE;
                    end
`ifdef AXI_RD_BURST_SPLIT_EN
                    else begin
                        advance = 1'b1;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        id_d   = pkt_id;
        len_d  = pkt_len;
        addr_d = pkt_addr;
        last_d = pkt_last;
`ifdef AXI_RD_BURST_SPLIT_EN
        avail = load ? ({1'b0, head.len} + ONE) : rem_q;
        beats = (avail > MAXB) ? MAXB : avail;
        rem_d = rem_q;
        if (load || advance) begin
            len_d  = LEN_W'(beats - ONE);
            rem_d  = avail - beats;
            last_d = (avail <= MAXB);
        end
        if (load) begin
            id_d   = head.id;
            addr_d = head.addr;
        end else if (advance) begin
            addr_d = pkt_addr + (ADDR_W'({1'b0, pkt_len} + ONE) << BEAT_SHIFT);
        end
`else
        if (load) begin
            id_d   = head.id;
            len_d  = head.len;
            addr_d = head.addr;
            last_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            pkt_id   <= '0;
            pkt_len  <= '0;
            pkt_addr <= '0;
            pkt_last <= 1'b0;
`ifdef AXI_RD_BURST_SPLIT_EN
            rem_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pkt_id   <= id_d;
            pkt_len  <= len_d;
            pkt_addr <= addr_d;
            pkt_last <= last_d;
`ifdef AXI_RD_BURST_SPLIT_EN
            rem_q    <= rem_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_rd_addr_splitter.sv
// tb/tb_axi_rd_addr_splitter.sv - self-checking bench for axi_rd_addr_splitter (either AXI_RD_BURST_SPLIT_EN build)
module tb_axi_rd_addr_splitter;
    localparam int ID_W = 4, LEN_W = 8, ADDR_W = 32, DEPTH = 4, MAX_BURST = 16, BEAT_BYTES = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [LEN_W-1:0]  arlen;
    logic [ADDR_W-1:0] araddr;
    logic              hold_in;
    logic              pkt_vld;
    logic [ID_W-1:0]   pkt_id;
    logic [LEN_W-1:0]  pkt_len;
    logic [ADDR_W-1:0] pkt_addr;
    logic              pkt_last;

    typedef struct {
        int          id;
        int          len;
        logic [31:0] addr;
        bit          last;
    } pkt_t;

    pkt_t exp_q[$];
    pkt_t seen_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    axi_rd_addr_splitter #(
        .ID_W(ID_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
        .DEPTH(DEPTH), .MAX_BURST(MAX_BURST), .BEAT_BYTES(BEAT_BYTES)
    ) dut (
        .clk(clk), .rst(rst), .arvalid(arvalid), .arready(arready),
        .arid(arid), .arlen(arlen), .araddr(araddr), .hold_in(hold_in),
        .pkt_vld(pkt_vld), .pkt_id(pkt_id), .pkt_len(pkt_len),
        .pkt_addr(pkt_addr), .pkt_last(pkt_last)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Expected packet list for one AR, derived from beat counts directly.
    task automatic model_push(input int id, input int len, input logic [31:0] addr);
        int          rem = len + 1;
        logic [31:0] a = addr;
        while (rem > 0) begin
            int   b;
            pkt_t p;
`ifdef AXI_RD_BURST_SPLIT_EN
            b = (rem > MAX_BURST) ? MAX_BURST : rem;
`else
            b = rem;
`endif
            p.id = id; p.len = b - 1; p.addr = a; p.last = (rem == b);
            exp_q.push_back(p);
            a   = a + 32'(b * BEAT_BYTES);
            rem = rem - b;
        end
    endtask

    always @(negedge clk) begin : chk
        pkt_t s;
        if (rst === 1'b1) begin
            if (arvalid && arready)
                model_push(int'(arid), int'(arlen), araddr);
            if (pkt_vld === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_pkt: got addr 0x%0h want no packet", pkt_addr);
                end else begin
                    check("pkt_id",   64'(pkt_id),   64'(exp_q[0].id));
                    check("pkt_len",  64'(pkt_len),  64'(exp_q[0].len));
                    check("pkt_addr", 64'(pkt_addr), 64'(exp_q[0].addr));
                    check("pkt_last", 64'(pkt_last), 64'(exp_q[0].last));
                    if (hold_in === 1'b0) begin
                        s.id = int'(pkt_id); s.len = int'(pkt_len); s.addr = pkt_addr; s.last = pkt_last;
                        seen_q.push_back(s);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_ar(input int id, input int len, input logic [31:0] addr);
        bit ok = 0;
        @(posedge clk); #1;
        arvalid = 1'b1; arid = ID_W'(id); arlen = LEN_W'(len); araddr = addr;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (arready === 1'b1) ok = 1;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        check("send_ar_accept", 64'(ok), 64'd1);
    endtask

    task automatic wait_vld(input string name);
        bit hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            if (pkt_vld === 1'b1) hit = 1;
        end
        check(name, 64'(hit), 64'd1);
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 600 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && pkt_vld === 1'b0) done = 1;
        end
        check(name, 64'(done), 64'd1);
    endtask

    initial begin
        bit hit;
        int mid_n;
        rst = 1'b0; arvalid = 1'b0; arid = '0; arlen = '0; araddr = '0; hold_in = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_arready",  64'(arready),  64'd0);
        check("rst_pkt_vld",  64'(pkt_vld),  64'd0);
        check("rst_pkt_id",   64'(pkt_id),   64'd0);
        check("rst_pkt_len",  64'(pkt_len),  64'd0);
        check("rst_pkt_addr", 64'(pkt_addr), 64'd0);
        check("rst_pkt_last", 64'(pkt_last), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("post_rst_arready", 64'(arready), 64'd1);

        // Basic flow and first-packet latency (accepted at edge N, visible after N+2)
        send_ar(3, 3, 32'h100);
        @(negedge clk); check("lat_after_n",  64'(pkt_vld), 64'd0);
        @(negedge clk); check("lat_after_n1", 64'(pkt_vld), 64'd0);
        @(negedge clk); check("lat_after_n2", 64'(pkt_vld), 64'd1);
        check("basic_id",   64'(pkt_id),   64'd3);
        check("basic_len",  64'(pkt_len),  64'd3);
        check("basic_addr", 64'(pkt_addr), 64'h100);
        check("basic_last", 64'(pkt_last), 64'd1);
        wait_drain("basic_drain");

        // Split of arlen=39
        seen_q.delete();
        send_ar(5, 39, 32'h1000);
        wait_vld("split_first_vld");
`ifdef AXI_RD_BURST_SPLIT_EN
        @(negedge clk); check("split_b2b_2", 64'(pkt_vld), 64'd1);
        @(negedge clk); check("split_b2b_3", 64'(pkt_vld), 64'd1);
`endif
        wait_drain("split_drain");
`ifdef AXI_RD_BURST_SPLIT_EN
        check("split_count", 64'(seen_q.size()), 64'd3);
        if (seen_q.size() == 3) begin
            int          lens[3]  = '{15, 15, 7};
            logic [31:0] addrs[3] = '{32'h1000, 32'h1040, 32'h1080};
            for (int i = 0; i < 3; i++) begin
                check("split_lit_len",  64'(seen_q[i].len),  64'(lens[i]));
                check("split_lit_addr", 64'(seen_q[i].addr), 64'(addrs[i]));
                check("split_lit_last", 64'(seen_q[i].last), 64'(i == 2));
                check("split_lit_id",   64'(seen_q[i].id),   64'd5);
            end
        end
`else
        check("nosplit_count", 64'(seen_q.size()), 64'd1);
        if (seen_q.size() == 1) begin
            check("nosplit_len",  64'(seen_q[0].len),  64'd39);
            check("nosplit_last", 64'(seen_q[0].last), 64'd1);
        end
`endif

        // FIFO full: one packet parked in the output register, then five ARs offered
        hold_in = 1'b1;
        send_ar(1, 0, 32'h300);
        wait_vld("full_park_vld");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            arvalid = 1'b1; arid = ID_W'(i + 2); arlen = LEN_W'(i); araddr = 32'h400 + 32'(i * 32'h10);
            @(negedge clk);
            check("full_arready", 64'(arready), 64'(i < 4));
        end
        @(posedge clk); #1;
        arvalid = 1'b0; hold_in = 1'b0;
        @(negedge clk); check("full_still_full", 64'(arready), 64'd0);
        @(negedge clk); check("full_after_pop",  64'(arready), 64'd1);
        wait_drain("full_drain");

        // Stall toggling during a split
        seen_q.delete();
        hold_in = 1'b1;
        send_ar(9, 39, 32'h4000);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1 hold_in = ~hold_in;
        end
        hold_in = 1'b0;
        wait_drain("stall_drain");
`ifdef AXI_RD_BURST_SPLIT_EN
        check("stall_count", 64'(seen_q.size()), 64'd3);
        if (seen_q.size() == 3) begin
            check("stall_addr0", 64'(seen_q[0].addr), 64'h4000);
            check("stall_addr1", 64'(seen_q[1].addr), 64'h4040);
            check("stall_addr2", 64'(seen_q[2].addr), 64'h4080);
        end
`else
        check("stall_count", 64'(seen_q.size()), 64'd1);
`endif

        // Reset in the middle of an arlen=63 split
        seen_q.delete();
`ifdef AXI_RD_BURST_SPLIT_EN
        mid_n = 2;
`else
        mid_n = 0;
`endif
        send_ar(2, 63, 32'h2000);
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(posedge clk); #1;
            if (seen_q.size() >= mid_n && pkt_vld === 1'b1) hit = 1;
        end
        check("midrst_reached", 64'(hit), 64'd1);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_pkt_vld", 64'(pkt_vld), 64'd0);
        check("midrst_arready", 64'(arready), 64'd0);
        check("midrst_addr",    64'(pkt_addr), 64'd0);
        @(posedge clk); #1 rst = 1'b1;
        seen_q.delete();
        send_ar(7, 0, 32'h20);
        wait_drain("midrst_drain");
        check("midrst_count", 64'(seen_q.size()), 64'd1);
        if (seen_q.size() == 1) begin
            check("midrst_new_addr", 64'(seen_q[0].addr), 64'h20);
            check("midrst_new_last", 64'(seen_q[0].last), 64'd1);
            check("midrst_new_len",  64'(seen_q[0].len),  64'd0);
        end

        // arlen = all-ones
        seen_q.delete();
        send_ar(10, 255, 32'h8000);
        wait_drain("max_drain");
`ifdef AXI_RD_BURST_SPLIT_EN
        check("max_count", 64'(seen_q.size()), 64'd16);
        if (seen_q.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                check("max_len",  64'(seen_q[i].len),  64'd15);
                check("max_addr", 64'(seen_q[i].addr), 64'(32'h8000 + 32'(i * 64)));
                check("max_last", 64'(seen_q[i].last), 64'(i == 15));
            end
        end
`else
        check("max_count", 64'(seen_q.size()), 64'd1);
        if (seen_q.size() == 1) begin
            check("max_len",  64'(seen_q[0].len),  64'd255);
            check("max_last", 64'(seen_q[0].last), 64'd1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/axi_rd_addr_splitter.md
AXI_RD_ADDR_SPLITTER -- requirements
Module: axi_rd_addr_splitter

Interface
REQ-001 SHALL have parameter ID_W, default 4, AXI read ID width.
REQ-002 SHALL have parameter LEN_W, default 8, AXI burst-length field width (beats minus 1).
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have parameter DEPTH, default 4, AR FIFO entries; power of two, at least 2.
REQ-005 SHALL have parameter MAX_BURST, default 16, maximum beats per output packet; power of two, at most 2**LEN_W.
REQ-006 SHALL have parameter BEAT_BYTES, default 4, byte stride per beat; power of two.
REQ-007 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- arvalid  in  1  AR request valid.
- arready  out  1  AR request accepted.
- arid  in  ID_W  AR ID.
- arlen  in  LEN_W  AR beats minus 1.
- araddr  in  ADDR_W  AR start address (INCR bursts only).
- hold_in  in  1  downstream stall; packet held while high.
- pkt_vld  out  1  output packet valid.
- pkt_id  out  ID_W  packet ID.
- pkt_len  out  LEN_W  packet beats minus 1.
- pkt_addr  out  ADDR_W  packet start address.
- pkt_last  out  1  final packet of the originating AR.

Function
REQ-008 SHALL drive arready = !fifo_full combinationally; an AR is accepted on a clock edge where arvalid && arready.
REQ-009 SHALL write {arid, arlen, araddr} into the FIFO on acceptance; no other path writes the FIFO.
REQ-010 SHALL hold the packet fields stable, with pkt_vld high, until the first edge where !hold_in.
REQ-011 SHALL consume the packet on an edge where pkt_vld && !hold_in.
REQ-012 SHALL implement a two-state FSM in the output stage:
- IDLE: pkt_vld is 0.
- ACTIVE: output register holds a packet.
REQ-013 SHALL, in IDLE with the FIFO non-empty, pop one entry and load the output register, entering ACTIVE.
REQ-014 SHALL set the first-packet latency: an AR accepted at edge N into an empty block gives pkt_vld = 1 after edge N+2.
REQ-015 SHALL, when the consumed packet is the final one and the FIFO is non-empty, pop and load the next entry on the same edge, staying in ACTIVE with no bubble.
REQ-016 SHALL, when the consumed packet is the final one and the FIFO is empty, return to IDLE.
REQ-017 SHALL allow FIFO push and pop on the same edge at any occupancy not full; occupancy is then unchanged.
REQ-018 SHALL never overflow or underflow: a push while full and a pop while empty are both impossible by construction.
REQ-019 SHALL compute remaining beats as arlen+1 at LEN_W+1 bits, so arlen = all-ones never wraps.
REQ-020 SHALL compute address increments modulo 2**ADDR_W (wrap permitted, not flagged).

Reset
REQ-021 SHALL, while rst is low, immediately clear: FIFO pointers and count, FSM to IDLE, pkt_vld, pkt_last, pkt_id, pkt_len, pkt_addr to 0.
REQ-022 SHALL drive arready = 0 while rst is low.
REQ-023 SHALL drive arready = 1 on the first edge after rst deasserts.
REQ-024 SHALL discard any in-progress split and all buffered entries on reset mid-operation; no partial packet reappears.

Configuration
REQ-025 SHALL, with AXI_RD_BURST_SPLIT_EN defined, split each AR into ceil((arlen+1)/MAX_BURST) packets in order:
- each packet carries min(remaining, MAX_BURST) beats;
- pkt_addr advances by beats*BEAT_BYTES per packet;
- pkt_id is unchanged across packets;
- pkt_last is 1 only on the final packet.
REQ-026 SHALL, with AXI_RD_BURST_SPLIT_EN defined, load each subsequent packet on the consuming edge (back-to-back, no bubble) and hold the FIFO pop until the final packet is consumed.
REQ-027 SHALL, without AXI_RD_BURST_SPLIT_EN, emit exactly one packet per AR with pkt_len = arlen, pkt_addr = araddr and pkt_last = 1, and omit all split counters.

Structure
REQ-028 SHALL take the default width constants and the parametrised address-packet struct (id, len, addr) from the shared package axi_ocp_pkg.
REQ-029 SHALL instantiate the team's existing parametrised FIFO sub-module with width $bits(packet) and depth DEPTH.
REQ-030 SHALL keep the splitter FSM inside this module, with no further sub-modules.

Verification
REQ-031 SHALL cover basic flow: after reset, one AR with arid=3, arlen=3, araddr=0x100 and hold_in=0 -> one packet two edges after acceptance with len=3, addr=0x100, last=1.
REQ-032 SHALL cover splitting (macro on, MAX_BURST=16): arlen=39, araddr=0x1000 -> three packets (len 15/15/7, addr 0x1000/0x1040/0x1080, last 0/0/1), all id equal, back-to-back.
REQ-033 SHALL cover FIFO full: DEPTH=4, hold_in=1, five ARs offered -> four accepted and arready=0 on the fifth; releasing hold_in -> arready returns to 1 one edge after the first pop.
REQ-034 SHALL cover stall: hold_in toggled 1/0 every cycle during a 3-packet split -> each packet held stable while stalled, none lost or duplicated, order preserved.
REQ-035 SHALL cover reset mid-split: rst asserted after the 2nd packet of an arlen=63 AR -> pkt_vld=0 immediately; the next AR (arlen=0, araddr=0x20) -> a single packet with addr=0x20, last=1.
REQ-036 SHALL cover edge cases: arlen=255 with the macro on -> 16 packets of len 15; with the macro off -> one packet with len=255, last=1.
